// File: rtl/regfile_writeback.sv
// regfile_writeback: write-port owner for the integer register file.
// Arbitrates ALU results (priority) against a FIFO of load completions and
// tracks a busy scoreboard for outstanding loads to raise a decode hazard.
// Optional feature macro: WB_BYPASS_EN (forward the write port to the
// decode operands and drop hazards that clear this cycle).
module regfile_writeback #(
    parameter int unsigned N_REG_ADDR    = 5,
    parameter int unsigned N_REG         = 32,
    parameter int unsigned N_DATA        = 32,
    parameter int unsigned LD_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [N_REG_ADDR-1:0] alu_rd,
    input  logic [N_DATA-1:0]     alu_data,
    input  logic                  ld_issue_valid,
    input  logic [N_REG_ADDR-1:0] ld_issue_rd,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [N_REG_ADDR-1:0] ld_rd,
    input  logic [N_DATA-1:0]     ld_data,
    input  logic [N_REG_ADDR-1:0] dec_rs1,
    input  logic [N_REG_ADDR-1:0] dec_rs2,
    input  logic [N_REG_ADDR-1:0] dec_rd,
    output logic                  hazard,
    input  logic [N_DATA-1:0]     rf_read_data_1,
    input  logic [N_DATA-1:0]     rf_read_data_2,
    output logic [N_DATA-1:0]     rs1_value,
    output logic [N_DATA-1:0]     rs2_value,
    output logic [N_REG_ADDR-1:0] addr_3,
    output logic                  write_enable_3,
    output logic [N_DATA-1:0]     write_data_3
);

    localparam int unsigned PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [N_REG_ADDR-1:0] fifo_rd   [LD_FIFO_DEPTH];
    logic [N_DATA-1:0]     fifo_data [LD_FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [N_REG-1:0]      busy;
    logic [N_REG-1:0]      busy_n;

    logic                  alu_wr;
    logic                  pop;
    logic                  push;
    logic [N_REG_ADDR-1:0] head_rd;
    logic [N_DATA-1:0]     head_data;
    logic                  busy_rs1;
    logic                  busy_rs2;
    logic                  busy_rd;

    // Write-port arbitration: ALU first, then FIFO head; nothing while in reset.
    always_comb begin
        head_rd        = fifo_rd[rd_ptr];
        head_data      = fifo_data[rd_ptr];
        alu_wr         = rst && alu_valid && (alu_rd != '0);
        pop            = rst && !alu_wr && (count != '0);
        ld_ready       = (count < CNT_W'(LD_FIFO_DEPTH));
        push           = ld_valid && ld_ready && (ld_rd != '0);
        write_enable_3 = 1'b0;
        addr_3         = '0;
        write_data_3   = '0;
        if (alu_wr) begin
            write_enable_3 = 1'b1;
            addr_3         = alu_rd;
            write_data_3   = alu_data;
        end else if (pop) begin
            write_enable_3 = 1'b1;
            addr_3         = head_rd;
            write_data_3   = head_data;
        end
    end

    // Scoreboard next state: clear on the head write, then set on issue (set wins).
    always_comb begin
        busy_n = busy;
        if (pop) begin
            busy_n[head_rd] = 1'b0;
        end
        if (ld_issue_valid && (ld_issue_rd != '0)) begin
            busy_n[ld_issue_rd] = 1'b1;
        end
        busy_n[0] = 1'b0;
    end

    // Decode hazard and operand selection.
    always_comb begin
        busy_rs1 = (dec_rs1 != '0) && busy[dec_rs1];
        busy_rs2 = (dec_rs2 != '0) && busy[dec_rs2];
        busy_rd  = (dec_rd  != '0) && busy[dec_rd];
`ifdef WB_BYPASS_EN
        // A source whose clearing load write is on the port now is forwarded.
        if (pop && (head_rd == dec_rs1)) begin
            busy_rs1 = 1'b0;
        end
        if (pop && (head_rd == dec_rs2)) begin
            busy_rs2 = 1'b0;
        end
        rs1_value = (write_enable_3 && (addr_3 == dec_rs1) && (dec_rs1 != '0))
                    ? write_data_3 : rf_read_data_1;
        rs2_value = (write_enable_3 && (addr_3 == dec_rs2) && (dec_rs2 != '0))
                    ? write_data_3 : rf_read_data_2;
`else
        rs1_value = rf_read_data_1;
        rs2_value = rf_read_data_2;
`endif
        hazard = busy_rs1 | busy_rs2 | busy_rd;
    end

    // Pointers, occupancy and scoreboard; reset discards buffered completions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            busy   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            busy  <= busy_n;
        end
    end

    // Completion storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= ld_rd;
            fifo_data[wr_ptr] <= ld_data;
        end
    end

endmodule
